// File: rtl/msb_grant_scheduler.sv
// Strict-priority single-resource arbiter: sticky pending requests, highest index
// granted, grant held until done or a hold timeout forces release.
module msb_grant_scheduler #(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 15
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         req_set,
    input  logic [WIDTH-1:0]         cancel,
    input  logic                     done,
    output logic                     gnt_valid,
    output logic [$clog2(WIDTH)-1:0] gnt_idx,
    output logic [WIDTH-1:0]         gnt_onehot,
    output logic [WIDTH-1:0]         pending,
    output logic                     timeout
);

    localparam int IDX_W     = $clog2(WIDTH);
    localparam int CNT_W_RAW = $clog2(MAX_HOLD + 1);
    localparam int CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t              state, state_n;
    logic [IDX_W-1:0]    idx_n;
    logic [CNT_W-1:0]    hold_cnt, cnt_n;
    logic [WIDTH-1:0]    pending_n, clr;
    logic [IDX_W-1:0]    sel;
    logic                any, expire, issue;

    // MSB priority encoder over the registered mask only.
    always_comb begin
        sel = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (pending[i]) sel = IDX_W'(i);
        end
    end

    assign any    = |pending;
    assign expire = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST) && !done;

    always_comb begin
        state_n = state;
        idx_n   = gnt_idx;
        cnt_n   = hold_cnt;
        issue   = 1'b0;
        unique case (state)
            IDLE: begin
                if (any) begin
                    issue   = 1'b1;
                    state_n = GRANT;
                end
            end
            GRANT: begin
                if (done || expire) begin
                    if (any) begin
                        issue = 1'b1;
                    end else begin
                        state_n = IDLE;
                        idx_n   = '0;
                    end
                end else if (hold_cnt != {CNT_W{1'b1}}) begin
                    cnt_n = hold_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        if (issue) begin
            idx_n = sel;
            cnt_n = '0;
        end
    end

    // The newly granted bit is consumed on the same edge, even if re-requested now.
    assign clr       = issue ? (WIDTH'(1) << sel) : '0;
    assign pending_n = (pending | req_set) & ~cancel & ~clr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            gnt_idx  <= '0;
            hold_cnt <= '0;
            pending  <= '0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_n;
            gnt_idx  <= idx_n;
            hold_cnt <= cnt_n;
            pending  <= pending_n;
            timeout  <= (state == GRANT) && expire;
        end
    end

    assign gnt_valid  = (state == GRANT);
    assign gnt_onehot = gnt_valid ? (WIDTH'(1) << gnt_idx) : '0;

endmodule

// File: tb/tb_msb_grant_scheduler.sv
// Bench for msb_grant_scheduler: directed scenarios plus random traffic, all
// outputs compared every cycle against a cycle-level behavioural model.
module tb_msb_grant_scheduler;

    localparam int WIDTH    = 8;
    localparam int MAX_HOLD = 15;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] req_set;
    logic [WIDTH-1:0] cancel;
    logic             done;
    logic             gnt_valid;
    logic [2:0]       gnt_idx;
    logic [WIDTH-1:0] gnt_onehot;
    logic [WIDTH-1:0] pending;
    logic             timeout;

    int errors = 0;
    int checks = 0;

    // behavioural model: pending set, current grant, age of the grant in edges
    bit [WIDTH-1:0] m_pend;
    bit             m_valid;
    int             m_idx;
    int             m_age;
    bit             m_to;

    msb_grant_scheduler #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_set   (req_set),
        .cancel    (cancel),
        .done      (done),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx),
        .gnt_onehot(gnt_onehot),
        .pending   (pending),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend  = '0;
        m_valid = 1'b0;
        m_idx   = 0;
        m_age   = 0;
        m_to    = 1'b0;
    endtask

    // One rising edge of the model, using the inputs presented during the cycle.
    task automatic model_edge(input bit [WIDTH-1:0] rq, input bit [WIDTH-1:0] cn, input bit dn);
        int  top;
        bit  release_now, expired, give;
        top = -1;
        for (int i = 0; i < WIDTH; i++) if (m_pend[i]) top = i;
        expired     = m_valid && (MAX_HOLD != 0) && !dn && (m_age + 1 == MAX_HOLD);
        release_now = m_valid && (dn || expired);
        give        = (top >= 0) && (!m_valid || release_now);
        m_to        = expired;
        m_pend      = (m_pend | rq) & ~cn;
        if (give) begin
            m_pend[top] = 1'b0;
            m_valid     = 1'b1;
            m_idx       = top;
            m_age       = 0;
        end else if (release_now) begin
            m_valid = 1'b0;
            m_idx   = 0;
            m_age   = 0;
        end else if (m_valid) begin
            m_age++;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"},   32'(gnt_valid),  32'(m_valid));
        chk({tag, ".idx"},     32'(gnt_idx),    32'(m_idx));
        chk({tag, ".onehot"},  32'(gnt_onehot), m_valid ? (32'd1 << m_idx) : 32'd0);
        chk({tag, ".pending"}, 32'(pending),    32'(m_pend));
        chk({tag, ".timeout"}, 32'(timeout),    32'(m_to));
    endtask

    // Drive one cycle of inputs, clock it, then compare just after the edge.
    task automatic step(input logic [WIDTH-1:0] rq, input logic [WIDTH-1:0] cn, input logic dn,
                        input string tag);
        req_set = rq;
        cancel  = cn;
        done    = dn;
        @(posedge clk);
        model_edge(rq, cn, dn);
        #1;
        check_all(tag);
    endtask

    initial begin
        reset   = 1'b1;
        req_set = '0;
        cancel  = '0;
        done    = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        reset = 1'b0;

        // basic grant and latency
        step(8'h14, 8'h00, 1'b0, "req14");
        chk("req14.pending_const", 32'(pending), 32'h14);
        chk("req14.novalid", 32'(gnt_valid), 32'd0);
        step(8'h00, 8'h00, 1'b0, "grant4");
        chk("grant4.idx_const", 32'(gnt_idx), 32'd4);
        chk("grant4.onehot_const", 32'(gnt_onehot), 32'h10);
        chk("grant4.pending_const", 32'(pending), 32'h04);
        step(8'h00, 8'h00, 1'b1, "done_to2");
        chk("done_to2.idx_const", 32'(gnt_idx), 32'd2);
        chk("done_to2.valid_const", 32'(gnt_valid), 32'd1);

        // cancel wins over a same-cycle request; then real request overtakes index 1
        step(8'h80, 8'h80, 1'b0, "set_cancel7");
        chk("set_cancel7.bit7", 32'(pending[7]), 32'd0);
        step(8'h82, 8'h00, 1'b0, "set7_1");
        step(8'h00, 8'h00, 1'b1, "done_to7");
        chk("done_to7.idx_const", 32'(gnt_idx), 32'd7);
        step(8'h00, 8'h04, 1'b0, "cancel_idle_bit");
        step(8'h00, 8'h80, 1'b0, "cancel_granted");
        chk("cancel_granted.still", 32'(gnt_valid), 32'd1);
        step(8'h00, 8'h00, 1'b1, "done_to1");
        step(8'h00, 8'h00, 1'b1, "done_idle");
        chk("done_idle.valid_const", 32'(gnt_valid), 32'd0);
        chk("done_idle.pending_const", 32'(pending), 32'd0);
        step(8'h00, 8'h00, 1'b1, "done_ignored");

        // hold timeout with a lower request waiting
        step(8'h08, 8'h00, 1'b0, "req3");
        step(8'h01, 8'h00, 1'b0, "grant3");
        for (int i = 1; i < MAX_HOLD; i++) step(8'h00, 8'h00, 1'b0, "hold3");
        chk("hold3.idx_const", 32'(gnt_idx), 32'd3);
        chk("hold3.noto", 32'(timeout), 32'd0);
        step(8'h00, 8'h00, 1'b0, "expire3");
        chk("expire3.to_const", 32'(timeout), 32'd1);
        chk("expire3.idx_const", 32'(gnt_idx), 32'd0);
        chk("expire3.valid_const", 32'(gnt_valid), 32'd1);
        step(8'h00, 8'h00, 1'b0, "after_expire");
        chk("after_expire.to_const", 32'(timeout), 32'd0);
        step(8'h00, 8'h00, 1'b1, "release0");

        // asynchronous reset mid-grant
        step(8'hFF, 8'h00, 1'b0, "fill");
        step(8'h00, 8'h00, 1'b0, "grant7");
        step(8'h80, 8'h00, 1'b0, "rearm7");
        chk("rearm7.pending_const", 32'(pending), 32'hFF);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all("async_reset");
        req_set = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) step(8'h00, 8'h00, 1'b0, "idle_after_reset");

        // random traffic
        for (int n = 0; n < 400; n++) begin
            logic [WIDTH-1:0] rq, cn;
            logic             dn;
            rq = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom) : '0;
            cn = ($urandom_range(0, 7) == 0) ? WIDTH'($urandom) : '0;
            dn = m_valid && ($urandom_range(0, 9) == 0);
            step(rq, cn, dn, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/msb_grant_scheduler.md
# msb_grant_scheduler

- Shares one single-user resource among WIDTH requesters.
- Requests are latched as sticky pending bits. The highest-index pending requester is granted, and the grant is held until the resource signals `done` or a hold timeout expires.
- Sits in front of the MSB-priority-encoder datapath: it sequences the encoder's input mask and turns its combinational index into a registered, handshaked grant.

## Interface
- `WIDTH`, 8 — number of requesters; must be ≥ 2.
- `MAX_HOLD`, 15 — maximum cycles a grant may be held before forced release; 0 disables the timeout.
- `clk` input 1 — single clock; all state updates on its rising edge.
- `reset` input 1 — asynchronous, active-high; clears all state immediately.
- `req_set` input WIDTH — a 1 on bit i for one or more cycles sets pending[i].
- `cancel` input WIDTH — a 1 on bit i clears pending[i].
- `done` input 1 — the granted user has finished; pulse only while `gnt_valid`=1.
- `gnt_valid` output 1 — a grant is active.
- `gnt_idx` output $clog2(WIDTH) — index of the granted requester; 0 when idle.
- `gnt_onehot` output WIDTH — one-hot of `gnt_idx` when `gnt_valid`=1, else 0.
- `pending` output WIDTH — the registered pending mask.
- `timeout` output 1 — one-cycle pulse on the cycle a grant is force-released.

## Operation
**States:**
- IDLE: `gnt_valid`=0.
- GRANT: `gnt_valid`=1, hold counter running.

**Pending update, every cycle:** pending ← (pending | req_set) & ~cancel & ~clr.
- clr is the one-hot of the newly granted index when a grant is issued this cycle, else 0.
- If `req_set` and `cancel` hit the same bit in the same cycle, `cancel` wins.

**Selection:**
- sel = index of the MSB of the registered pending value (not including this cycle's `req_set`).
- any = (pending ≠ 0).

**Transitions:**
- IDLE & any → GRANT:
  - `gnt_idx` ← sel.
  - pending[sel] cleared.
  - hold counter ← 0.
- GRANT & (`done` | expire) & any → stays in GRANT; re-grants sel with the same side effects as above. There is no idle gap.
- GRANT & (`done` | expire) & !any → IDLE; `gnt_idx` ← 0.
- GRANT otherwise: the hold counter increments and saturates.
- expire = (MAX_HOLD ≠ 0) & (hold counter == MAX_HOLD−1) & !`done`.
  - `timeout` is registered: it is high the cycle after expire.
- `done` in IDLE is ignored.

**Boundary rules:**
- `cancel` of the currently granted index does not revoke the grant; its pending bit is already clear.
- A new `req_set` from the granted requester during its grant re-arms its pending bit.
- Strict priority: a higher index always wins, and starvation of low indices is permitted by design.
- Hold counter width is $clog2(MAX_HOLD+1), minimum 1.
- `reset` mid-grant: state immediately returns to IDLE and all outputs go to 0. Pending requests are lost.

## Timing
**Reset values:**
- `gnt_valid`=0, `gnt_idx`=0, `gnt_onehot`=0, `pending`=0, `timeout`=0.
- State IDLE, hold counter 0.

**Latencies and outputs:**
- `req_set` sampled at edge N → `pending` visible after edge N → `gnt_valid` high after edge N+1. Request-to-grant latency is 2 cycles from idle.
- `done` sampled at edge M → the new grant (or `gnt_valid`=0) is visible after edge M.
- Without `done`, a grant issued at edge G is released at edge G+MAX_HOLD, and `timeout` is high for the cycle after that edge.
- All outputs are registered.
- `gnt_onehot` is derived combinationally from the registered `gnt_idx`/`gnt_valid` only.

## Test plan
- Reset, then `req_set`=8'b0001_0100 for one cycle → `pending`=0x14 after 1 edge. After 2 edges, `gnt_idx`=4, `gnt_onehot`=0x10, `pending`=0x04.
- In GRANT(idx 4), pulse `done` → next cycle `gnt_idx`=2 with `gnt_valid` held high. Pulse `done` again → `gnt_valid`=0, `gnt_idx`=0, `pending`=0.
- While `gnt_idx`=2, set `req_set`[7]=1 and `cancel`[7]=1 together → `pending`[7] stays 0. Then set `req_set`[7] alone → after `done`, `gnt_idx`=7 (priority over index 1 if also pending).
- MAX_HOLD=15, grant idx 3, never assert `done` → released 15 edges after the grant, `timeout` pulses for exactly 1 cycle, and the next pending index is granted on that same edge.
- Assert `reset` asynchronously mid-grant with `pending`=0xFF → all outputs are 0 before the next clock edge. After deassertion with no requests, the block stays idle.
